// File: rtl/dmgplus_splash_loader_if.sv
// ROM read port and splash VRAM write port of the DMG+ splash loader.
// The loader is the master; the cart ROM / VRAM side is the slave.
interface dmgplus_splash_loader_if #(
  parameter int BPP = 2
);
  logic [15:0]    rom_addr;
  logic [7:0]     rom_data;
  logic           rom_rd;
  logic           rom_bsy;
  logic [15:0]    vramaddr;
  logic [BPP-1:0] vramdata;
  logic           vramwe;

  modport master (
    output rom_addr, rom_rd, vramaddr, vramdata, vramwe,
    input  rom_data, rom_bsy
  );

  modport slave (
    input  rom_addr, rom_rd, vramaddr, vramdata, vramwe,
    output rom_data, rom_bsy
  );
endinterface

// File: rtl/dmgplus_splash_loader.sv
// DMG+ splash loader: probes the cart header for the DMG+ signature, streams the
// splash image (raw or RLE) from ROM into VRAM, then times the splash hold period.
module dmgplus_splash_loader #(
  parameter int          BPP        = 2,
  parameter int          IMG_W      = 160,
  parameter int          IMG_H      = 144,
  parameter logic [31:0] SIG        = 32'h444D472B,
  parameter logic [15:0] SIG_ADDR   = 16'h0100,
  parameter logic [15:0] DELAY_ADDR = 16'h00FE,
  parameter logic [15:0] MODE_ADDR  = 16'h0104,
  parameter logic [15:0] IMG_ADDR   = 16'h0134,
  parameter int          DELAY_BIAS = 130
) (
  input  logic                    clk_8m,
  input  logic                    rst,
  input  logic                    ena,
  input  logic                    lcd_newframe,
  dmgplus_splash_loader_if.master bus,
  output logic                    is_dmgplus,
  output logic                    rle_mode,
  output logic                    rom_read_done,
  output logic                    splash_done
);

  localparam logic [2:0] S_HDR_REQ  = 3'd0;
  localparam logic [2:0] S_HDR_WAIT = 3'd1;
  localparam logic [2:0] S_IMG_REQ  = 3'd2;
  localparam logic [2:0] S_IMG_WAIT = 3'd3;
  localparam logic [2:0] S_PIX      = 3'd4;
  localparam logic [2:0] S_DONE     = 3'd5;
  localparam logic [2:0] S_DELAY    = 3'd6;

  localparam logic [7:0]  X_LAST  = 8'(IMG_W - 1);
  localparam logic [7:0]  Y_LAST  = 8'(IMG_H - 1);
  localparam logic [8:0]  RAW_PIX = 9'(8 / BPP);
  localparam logic [16:0] BIAS    = 17'(DELAY_BIAS);

  logic [2:0]     state_r;
  logic [2:0]     hdr_idx_r;
  logic [15:0]    delay_r;
  logic [7:0]     byte_r;
  logic [8:0]     pix_left_r;
  logic [7:0]     xpos_r;
  logic [7:0]     ypos_r;
  logic [15:0]    frame_cnt_r;
  logic           done_d_r;

  logic           sample_s;
  logic           last_pix_s;
  logic [BPP-1:0] pix_s;
  logic [8:0]     run_s;
  logic [16:0]    diff_s;
  logic [15:0]    target_s;
  logic [15:0]    frame_nxt_s;

  function automatic logic [7:0] sig_byte(input logic [2:0] idx);
    case (idx)
      3'd2:    sig_byte = SIG[31:24];
      3'd3:    sig_byte = SIG[23:16];
      3'd4:    sig_byte = SIG[15:8];
      default: sig_byte = SIG[7:0];
    endcase
  endfunction

  // Datapath helpers: ROM sample strobe, pixel select, delay target, frame count.
  always_comb begin
    sample_s   = !bus.rom_rd && !bus.rom_bsy;
    last_pix_s = (xpos_r == X_LAST) && (ypos_r == Y_LAST);
    run_s      = 9'(bus.rom_data[7:BPP]) + 9'd1;
    if (rle_mode) begin
      pix_s = byte_r[BPP-1:0];
    end else begin
      pix_s = byte_r[7 -: BPP];
    end
    diff_s = {1'b0, delay_r} - BIAS;
    if (diff_s[16]) begin
      target_s = 16'h0000;
    end else begin
      target_s = diff_s[15:0];
    end
    // Frames only count once rom_read_done has been high for a full cycle.
    if (rom_read_done && done_d_r && lcd_newframe && (frame_cnt_r != 16'hFFFF)) begin
      frame_nxt_s = frame_cnt_r + 16'd1;
    end else begin
      frame_nxt_s = frame_cnt_r;
    end
  end

  // Loader FSM with all outputs registered.
  always_ff @(posedge clk_8m) begin
    if (rst || !ena) begin
      state_r       <= S_HDR_REQ;
      hdr_idx_r     <= 3'd0;
      delay_r       <= 16'h0000;
      byte_r        <= 8'h00;
      pix_left_r    <= 9'd0;
      xpos_r        <= 8'd0;
      ypos_r        <= 8'd0;
      frame_cnt_r   <= 16'h0000;
      done_d_r      <= 1'b0;
      bus.rom_addr  <= DELAY_ADDR;
      bus.rom_rd    <= 1'b0;
      bus.vramaddr  <= 16'h0000;
      bus.vramdata  <= '0;
      bus.vramwe    <= 1'b0;
      is_dmgplus    <= 1'b0;
      rle_mode      <= 1'b0;
      rom_read_done <= 1'b0;
      splash_done   <= 1'b0;
    end else begin
      bus.rom_rd <= 1'b0;
      bus.vramwe <= 1'b0;
      done_d_r   <= rom_read_done;
      case (state_r)
        S_HDR_REQ: begin
          bus.rom_rd <= 1'b1;
          if (hdr_idx_r == 3'd6) begin
            is_dmgplus <= 1'b1;
          end
          state_r <= S_HDR_WAIT;
        end
        S_HDR_WAIT: begin
          if (sample_s) begin
            case (hdr_idx_r)
              3'd0: begin
                delay_r[7:0] <= bus.rom_data;
                bus.rom_addr <= DELAY_ADDR + 16'd1;
                hdr_idx_r    <= 3'd1;
                state_r      <= S_HDR_REQ;
              end
              3'd1: begin
                delay_r[15:8] <= bus.rom_data;
                bus.rom_addr  <= SIG_ADDR;
                hdr_idx_r     <= 3'd2;
                state_r       <= S_HDR_REQ;
              end
              3'd2, 3'd3, 3'd4, 3'd5: begin
                if (bus.rom_data != sig_byte(hdr_idx_r)) begin
                  rom_read_done <= 1'b1;
                  state_r       <= S_DONE;
                end else begin
                  bus.rom_addr <= (hdr_idx_r == 3'd5) ? MODE_ADDR : (bus.rom_addr + 16'd1);
                  hdr_idx_r    <= hdr_idx_r + 3'd1;
                  state_r      <= S_HDR_REQ;
                end
              end
              default: begin
                rle_mode     <= bus.rom_data[0];
                bus.rom_addr <= IMG_ADDR;
                state_r      <= S_IMG_REQ;
              end
            endcase
          end
        end
        S_IMG_REQ: begin
          bus.rom_rd <= 1'b1;
          state_r    <= S_IMG_WAIT;
        end
        S_IMG_WAIT: begin
          if (sample_s) begin
            byte_r     <= bus.rom_data;
            pix_left_r <= rle_mode ? run_s : RAW_PIX;
            state_r    <= S_PIX;
          end
        end
        S_PIX: begin
          bus.vramwe   <= 1'b1;
          bus.vramaddr <= {ypos_r, xpos_r};
          bus.vramdata <= pix_s;
          pix_left_r   <= pix_left_r - 9'd1;
          if (!rle_mode) begin
            byte_r <= byte_r << BPP;
          end
          // The final pixel ends the load even if the current run is unfinished.
          if (last_pix_s) begin
            state_r <= S_DONE;
          end else begin
            if (xpos_r == X_LAST) begin
              xpos_r <= 8'd0;
              ypos_r <= ypos_r + 8'd1;
            end else begin
              xpos_r <= xpos_r + 8'd1;
            end
            if (pix_left_r == 9'd1) begin
              bus.rom_addr <= bus.rom_addr + 16'd1;
              state_r      <= S_IMG_REQ;
            end
          end
        end
        S_DONE: begin
          rom_read_done <= 1'b1;
          if (!is_dmgplus) begin
            splash_done <= 1'b1;
          end
          state_r <= S_DELAY;
        end
        S_DELAY: begin
          frame_cnt_r <= frame_nxt_s;
          if (is_dmgplus && (frame_nxt_s >= target_s)) begin
            splash_done <= 1'b1;
          end
        end
        default: begin
          state_r <= S_HDR_REQ;
        end
      endcase
    end
  end

endmodule
